// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // Width of the step counter that walks 0..width-1.
    function automatic int step_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mul_seq_signed_if.sv
// Operand/product handshake bundle for mul_seq_signed: valid/ready on both sides.
interface mul_seq_signed_if #(
    parameter int WIDTH = 16
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic                 in_signed;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;
    logic                 busy;

    modport master (
        output in_valid, in_signed, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p, busy
    );

    modport slave (
        input  in_valid, in_signed, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p, busy
    );

endinterface

// File: rtl/mul_acc_step.sv
// One shift-add stage: acc +/- (ax << k) when the multiplier bit is set.
// Purely combinational; no handshake.
module mul_acc_step
    import mul_pkg::*;
#(
    parameter  int WIDTH  = 16,
    localparam int STEP_W = step_w(WIDTH)
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] ax_i,
    input  logic [STEP_W-1:0]  k_i,
    input  logic               b_bit_i,
    input  logic               sub_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [2*WIDTH-1:0] pp;

    always_comb begin
        pp    = ax_i << k_i;
        acc_o = acc_i;
        if (b_bit_i) begin
            acc_o = sub_i ? (acc_i - pp) : (acc_i + pp);
        end
    end

endmodule

// File: rtl/mul_seq_signed.sv
// Iterative WIDTH x WIDTH signed/unsigned multiplier, one partial product per cycle.
// Latency WIDTH+1 cycles from input handshake to out_valid; result held while out_ready is low.
module mul_seq_signed
    import mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mul_seq_signed_if.slave   bus
);

    localparam int                PW     = 2 * WIDTH;
    localparam int                STEP_W = step_w(WIDTH);
    localparam logic [STEP_W-1:0] LAST   = STEP_W'(WIDTH - 1);

    mul_state_e        state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              sgn_q;
    logic [STEP_W-1:0] step_q;
    logic [PW-1:0]     acc_q;
    logic [PW-1:0]     acc_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    logic [PW-1:0]     ax;
    logic              sub;

    assign ax  = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    // Only the top multiplier bit of a signed operand carries negative weight.
    assign sub = sgn_q && (step_q == LAST);

    mul_acc_step #(.WIDTH(WIDTH)) u_step (
        .acc_i   (acc_q),
        .ax_i    (ax),
        .k_i     (step_q),
        .b_bit_i (b_q[step_q]),
        .sub_i   (sub),
        .acc_o   (acc_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sgn_q       <= 1'b0;
            step_q      <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.in_a;
                        b_q        <= bus.in_b;
                        sgn_q      <= bus.in_signed;
                        acc_q      <= '0;
                        step_q     <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    if (step_q == LAST) begin
                        state_q <= DONE;
                    end else begin
                        step_q <= step_q + STEP_W'(1);
                    end
                end
                DONE: begin
                    // out_valid rises one cycle after entering DONE, giving WIDTH+1 latency.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = acc_q;
    assign bus.busy      = busy_q;

endmodule
